// File: rtl/axi_lite_rr_master_if.sv
// rtl/axi_lite_rr_master_if.sv - AXI4-Lite bus bundle between the round-robin master and its register slave
interface axi_lite_rr_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic              RVALID;
    logic [1:0]        RRESP;
    logic              RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RVALID, RRESP
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RVALID, RRESP
    );
endinterface

// File: rtl/axi_lite_rr_master.sv
// rtl/axi_lite_rr_master.sv - round-robin arbiter sharing one AXI4-Lite slave among NUM_REQ command ports
module axi_lite_rr_master #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_resp,
    axi_lite_rr_master_if.master      axi
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   idx;
    logic               grant_found;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               awvalid_q;
    logic               wvalid_q;

    // Scan starts just after the last winner, so the last winner has lowest priority.
    always_comb begin
        grant       = last_q;
        grant_found = 1'b0;
        idx         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDX_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant] = ARESETn;
                    state_d = req_write[grant] ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                if ((!awvalid_q || axi.AWREADY) && (!wvalid_q || axi.WREADY)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi.BVALID) begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                if (axi.ARREADY) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi.RVALID) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign axi.AWADDR  = addr_q;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = (state_q == WR_RESP);
    assign axi.ARADDR  = addr_q;
    assign axi.ARVALID = (state_q == RD_ADDR);
    assign axi.RREADY  = (state_q == RD_DATA);

    // last_q doubles as the owner of the in-flight transaction for the response pulse.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            last_q    <= IDX_W'(NUM_REQ - 1);
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            rsp_valid <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        last_q    <= grant;
                        addr_q    <= sel_addr;
                        wdata_q   <= sel_wdata;
                        awvalid_q <= req_write[grant];
                        wvalid_q  <= req_write[grant];
                    end
                end
                WR_ADDR_DATA: begin
                    if (axi.AWREADY) awvalid_q <= 1'b0;
                    if (axi.WREADY)  wvalid_q  <= 1'b0;
                end
                WR_RESP: begin
                    if (axi.BVALID) begin
                        rsp_valid[last_q] <= 1'b1;
                        rsp_rdata         <= '0;
                        rsp_resp          <= axi.BRESP;
                    end
                end
                RD_DATA: begin
                    if (axi.RVALID) begin
                        rsp_valid[last_q] <= 1'b1;
                        rsp_rdata         <= axi.RDATA;
                        rsp_resp          <= axi.RRESP;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_rr_master.sv
// tb/tb_axi_lite_rr_master.sv - directed self-checking bench for axi_lite_rr_master with a delay-programmable slave
module tb_axi_lite_rr_master;
    localparam int NR = 2;
    localparam int AW = 4;
    localparam int DW = 32;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_resp;

    axi_lite_rr_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    axi_lite_rr_master #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .axi       (bus)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave configuration (written by the main sequence) and slave-side state.
    int          aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
    logic [1:0]  resp_cfg = 2'b00;
    logic        slave_clear = 1'b1;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit          aw_got, w_got, ar_got, b_hs, r_hs;
    bit          aw_pend, w_pend, ar_pend;
    logic [3:0]  aw_addr_c, ar_addr_c, aw_addr_p, ar_addr_p;
    logic [31:0] w_data_c, w_data_p;
    logic [31:0] mem [4];
    int          viol = 0;

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
        bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0;
        aw_addr_c = 0; ar_addr_c = 0; w_data_c = 0;
        forever begin
            @(negedge ACLK);
            if (slave_clear) begin
                bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.ARREADY = 0; bus.RVALID = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
                aw_pend = 0; w_pend = 0; ar_pend = 0;
            end else begin
                if (aw_pend && (!bus.AWVALID || bus.AWADDR !== aw_addr_p)) viol++;
                if (w_pend && (!bus.WVALID || bus.WDATA !== w_data_p)) viol++;
                if (ar_pend && (!bus.ARVALID || bus.ARADDR !== ar_addr_p)) viol++;
                if ((bus.AWVALID || bus.WVALID || aw_got || w_got) && (bus.ARVALID || ar_got)) viol++;
                // B/R are decided before this cycle's AW/W/AR so a response never precedes its request.
                if (b_hs) begin
                    bus.BVALID = 0; b_hs = 0; aw_got = 0; w_got = 0; b_cnt = 0;
                end else if (aw_got && w_got && !bus.BVALID) begin
                    if (b_cnt >= b_d) begin
                        bus.BVALID = 1; bus.BRESP = resp_cfg;
                    end else b_cnt++;
                end
                if (bus.BVALID && bus.BREADY) begin
                    b_hs = 1;
                    if (resp_cfg == 2'b00) mem[aw_addr_c[3:2]] = w_data_c;
                end
                if (r_hs) begin
                    bus.RVALID = 0; r_hs = 0; ar_got = 0; r_cnt = 0;
                end else if (ar_got && !bus.RVALID) begin
                    if (r_cnt >= r_d) begin
                        bus.RVALID = 1; bus.RDATA = mem[ar_addr_c[3:2]]; bus.RRESP = resp_cfg;
                    end else r_cnt++;
                end
                if (bus.RVALID && bus.RREADY) r_hs = 1;
                if (bus.AWVALID && !aw_got) begin
                    bus.AWREADY = (aw_cnt >= aw_d); aw_cnt++;
                    if (bus.AWREADY) begin aw_got = 1; aw_addr_c = bus.AWADDR; end
                end else begin
                    if (bus.AWVALID) viol++;
                    bus.AWREADY = 0; aw_cnt = 0;
                end
                if (bus.WVALID && !w_got) begin
                    bus.WREADY = (w_cnt >= w_d); w_cnt++;
                    if (bus.WREADY) begin w_got = 1; w_data_c = bus.WDATA; end
                end else begin
                    if (bus.WVALID) viol++;
                    bus.WREADY = 0; w_cnt = 0;
                end
                if (bus.ARVALID && !ar_got) begin
                    bus.ARREADY = (ar_cnt >= ar_d); ar_cnt++;
                    if (bus.ARREADY) begin ar_got = 1; ar_addr_c = bus.ARADDR; end
                end else begin
                    if (bus.ARVALID) viol++;
                    bus.ARREADY = 0; ar_cnt = 0;
                end
                aw_pend = bus.AWVALID && !bus.AWREADY; aw_addr_p = bus.AWADDR;
                w_pend  = bus.WVALID && !bus.WREADY;   w_data_p  = bus.WDATA;
                ar_pend = bus.ARVALID && !bus.ARREADY; ar_addr_p = bus.ARADDR;
            end
        end
    end

    task automatic do_cmd(input int r, input logic wr, input logic [3:0] a, input logic [31:0] d,
                          output logic [1:0] gv, output logic [31:0] grd, output logic [1:0] grs, output int lat);
        int t;
        gv = 0; grd = 0; grs = 0; lat = -1;
        @(negedge ACLK);
        req_valid[r] = 1'b1; req_write[r] = wr;
        req_addr[r*AW +: AW] = a; req_wdata[r*DW +: DW] = d;
        #1;
        t = 0;
        while (!req_ready[r] && t < 50) begin
            @(negedge ACLK); #1; t++;
        end
        if (!req_ready[r]) begin
            req_valid[r] = 1'b0;
            return;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge ACLK);
            if (c == 1) req_valid[r] = 1'b0;
            #1;
            if (rsp_valid != 0) begin
                gv = rsp_valid; grd = rsp_rdata; grs = rsp_resp; lat = c;
                break;
            end
        end
    endtask

    function automatic logic [63:0] all_out();
        return {req_ready, rsp_valid, rsp_resp, bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY,
                bus.AWADDR, bus.ARADDR, rsp_rdata};
    endfunction

    typedef struct packed {
        int          r;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wd;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  resp;
        logic [1:0]  e_valid;
        logic [31:0] e_rdata;
        logic [1:0]  e_resp;
        int          e_lat;
    } vec_t;

    vec_t        vt [10];
    logic [1:0]  gv, grs;
    logic [31:0] grd;
    int          lat;

    initial begin
        vt[0] = '{0, 1'b1, 4'h4, 32'hDEADBEEF, 1, 1, 0, 0, 0, 2'b00, 2'b01, 32'h0,        2'b00, 4};
        vt[1] = '{1, 1'b0, 4'h4, 32'h0,        0, 0, 0, 0, 0, 2'b00, 2'b10, 32'hDEADBEEF, 2'b00, 3};
        vt[2] = '{0, 1'b1, 4'h0, 32'h12345678, 0, 0, 0, 0, 0, 2'b00, 2'b01, 32'h0,        2'b00, 3};
        vt[3] = '{1, 1'b1, 4'hC, 32'hA5A50F0F, 0, 3, 0, 0, 0, 2'b00, 2'b10, 32'h0,        2'b00, 6};
        vt[4] = '{0, 1'b1, 4'h8, 32'h0BADF00D, 3, 0, 0, 0, 0, 2'b00, 2'b01, 32'h0,        2'b00, 6};
        vt[5] = '{1, 1'b1, 4'h8, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 2'b10, 2'b10, 32'h0,        2'b10, 3};
        vt[6] = '{0, 1'b0, 4'h0, 32'h0,        0, 0, 0, 0, 0, 2'b11, 2'b01, 32'h12345678, 2'b11, 3};
        vt[7] = '{1, 1'b0, 4'h8, 32'h0,        0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h0BADF00D, 2'b00, 3};
        vt[8] = '{0, 1'b0, 4'hC, 32'h0,        0, 0, 0, 1, 2, 2'b00, 2'b01, 32'hA5A50F0F, 2'b00, 6};
        vt[9] = '{1, 1'b1, 4'h0, 32'h00000001, 0, 0, 2, 0, 0, 2'b00, 2'b10, 32'h0,        2'b00, 5};

        ARESETn = 0; slave_clear = 1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        repeat (3) @(negedge ACLK);
        #1 chk("reset outputs", all_out(), 64'h0);
        @(negedge ACLK);
        req_valid = 2'b11;
        #1 chk("reset req_ready gated", {62'h0, req_ready}, 64'h0);
        @(negedge ACLK);
        req_valid = 0; ARESETn = 1; slave_clear = 0;

        for (int i = 0; i < 10; i++) begin
            aw_d = vt[i].aw_d; w_d = vt[i].w_d; b_d = vt[i].b_d;
            ar_d = vt[i].ar_d; r_d = vt[i].r_d; resp_cfg = vt[i].resp;
            do_cmd(vt[i].r, vt[i].wr, vt[i].addr, vt[i].wd, gv, grd, grs, lat);
            chk($sformatf("v%0d rsp_valid", i), {62'h0, gv}, {62'h0, vt[i].e_valid});
            chk($sformatf("v%0d rsp_rdata", i), {32'h0, grd}, {32'h0, vt[i].e_rdata});
            chk($sformatf("v%0d rsp_resp", i), {62'h0, grs}, {62'h0, vt[i].e_resp});
            chk($sformatf("v%0d latency", i), 64'(lat), 64'(vt[i].e_lat));
            chk($sformatf("v%0d bus addr", i), {60'h0, (vt[i].wr ? aw_addr_c : ar_addr_c)}, {60'h0, vt[i].addr});
            if (vt[i].wr) chk($sformatf("v%0d WDATA", i), {32'h0, w_data_c}, {32'h0, vt[i].wd});
            @(negedge ACLK);
            #1 chk($sformatf("v%0d hold", i), {30'h0, rsp_valid, rsp_rdata, rsp_resp},
                   {30'h0, 2'b00, vt[i].e_rdata, vt[i].e_resp});
        end

        begin : contention
            int         g[2], rc[2], order[$];
            int         outst, ovl;
            logic [7:0] ord_bits;
            g = '{0, 0}; rc = '{0, 0}; outst = 0; ovl = 0; ord_bits = 0;
            aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0; resp_cfg = 0;
            @(negedge ACLK);
            req_write = 0; req_addr = {4'h4, 4'h4}; req_valid = 2'b11;
            for (int cyc = 0; cyc < 300 && !(rc[0] == 4 && rc[1] == 4); cyc++) begin
                #1;
                for (int i = 0; i < 2; i++) if (rsp_valid[i]) begin rc[i]++; outst--; end
                for (int i = 0; i < 2; i++) if (req_ready[i]) begin
                    g[i]++; order.push_back(i); outst++;
                    if (outst > 1) ovl++;
                end
                @(negedge ACLK);
                for (int i = 0; i < 2; i++) req_valid[i] = (g[i] < 4);
            end
            req_valid = 0;
            for (int k = 0; k < order.size() && k < 8; k++) ord_bits[k] = order[k][0];
            chk("contention grant count", 64'(order.size()), 64'd8);
            chk("contention grant order", {56'h0, ord_bits}, 64'hAA);
            chk("contention rsp req0", 64'(rc[0]), 64'd4);
            chk("contention rsp req1", 64'(rc[1]), 64'd4);
            chk("contention overlap", 64'(ovl), 64'd0);
        end

        begin : reset_mid_read
            int t;
            logic [1:0] seen;
            r_d = 1000;
            do_cmd(0, 1'b0, 4'h4, 32'h0, gv, grd, grs, lat);
            chk("mid-read no early rsp", {62'h0, gv}, 64'h0);
            t = 0;
            while (!bus.RREADY && t < 20) begin @(negedge ACLK); #1; t++; end
            chk("mid-read reached RD_DATA", {63'h0, bus.RREADY}, 64'h1);
            ARESETn = 0; slave_clear = 1;
            @(negedge ACLK);
            #1 chk("mid-read reset outputs", all_out(), 64'h0);
            @(negedge ACLK);
            ARESETn = 1; slave_clear = 0; r_d = 0;
            seen = 0;
            repeat (3) begin @(negedge ACLK); #1 seen = seen | rsp_valid; end
            chk("mid-read discarded", {62'h0, seen}, 64'h0);
            @(negedge ACLK);
            req_write = 0; req_addr = {4'h4, 4'h4}; req_valid = 2'b11;
            #1 chk("post-reset first grant", {62'h0, req_ready}, 64'h1);
            @(negedge ACLK);
            req_valid = 0;
            gv = 0; grd = 0;
            for (int c = 0; c < 20 && gv == 0; c++) begin
                #1;
                if (rsp_valid != 0) begin gv = rsp_valid; grd = rsp_rdata; end
                @(negedge ACLK);
            end
            chk("post-reset rsp_valid", {62'h0, gv}, 64'h1);
            chk("post-reset rsp_rdata", {32'h0, grd}, 64'hDEADBEEF);
        end

        chk("protocol violations", 64'(viol), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
